// File: rtl/jk_async.sv
// jk_async: WIDTH independent clocked JK flip-flops with synchronous active-high reset.
// Define JK_ASYNC_QN_EN to add the complementary output qn (= ~q).
module jk_async #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
`ifdef JK_ASYNC_QN_EN
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
`else
  output logic [WIDTH-1:0] q
`endif
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Per-bit JK equation: set when j and currently 0, keep when ~k and currently 1.
  always_comb begin
    q_d = (j & ~q_q) | (~k & q_q);
  end

  // Reset is tested first so X/Z on j or k cannot leak into q while reset is high.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

`ifdef JK_ASYNC_QN_EN
  assign qn = ~q_q;
`endif

endmodule

// File: tb/tb_jk_async.sv
// Directed self-checking bench for jk_async: a WIDTH=1 and a WIDTH=4 instance share clk/reset.
// Inputs change mid-low-phase; outputs are sampled 1 ns after each rising edge.
module tb_jk_async;

  logic       clk = 1'b0;
  logic       reset;
  logic       j1, k1;
  logic       q1;
  logic [3:0] j4, k4;
  logic [3:0] q4;
`ifdef JK_ASYNC_QN_EN
  logic       qn1;
  logic [3:0] qn4;
`endif

  int checks   = 0;
  int failures = 0;

  always #50 clk = ~clk;

  jk_async #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .j     (j1),
    .k     (k1),
`ifdef JK_ASYNC_QN_EN
    .q     (q1),
    .qn    (qn1)
`else
    .q     (q1)
`endif
  );

  jk_async #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .j     (j4),
    .k     (k4),
`ifdef JK_ASYNC_QN_EN
    .q     (q4),
    .qn    (qn4)
`else
    .q     (q4)
`endif
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_q1(input string tag, input logic exp);
    check(tag, {3'b000, q1}, {3'b000, exp});
`ifdef JK_ASYNC_QN_EN
    check({tag, "_qn"}, {3'b000, qn1}, {3'b000, ~exp});
`endif
  endtask

  task automatic check_q4(input string tag, input logic [3:0] exp);
    check(tag, q4, exp);
`ifdef JK_ASYNC_QN_EN
    check({tag, "_qn"}, qn4, ~exp);
`endif
  endtask

  // Drive inputs in the middle of the low phase, then sample just after the next rising edge.
  task automatic drive1(input logic r, input logic j, input logic k);
    @(negedge clk);
    #20;
    reset = r;
    j1    = j;
    k1    = k;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic j;
    logic k;
    logic exp;
    string tag;
  } vec_t;

  vec_t seq[5];

  initial begin
    seq[0] = '{1'b0, 1'b0, 1'b0, "hold"};
    seq[1] = '{1'b0, 1'b1, 1'b0, "clear"};
    seq[2] = '{1'b1, 1'b0, 1'b1, "set"};
    seq[3] = '{1'b1, 1'b1, 1'b0, "toggle_a"};
    seq[4] = '{1'b1, 1'b1, 1'b1, "toggle_b"};

    reset = 1'b1;
    j1    = 1'bx;
    k1    = 1'bx;
    j4    = 4'b0000;
    k4    = 4'b0000;

    // Reset across the first edge with j/k unknown, then held for three more edges.
    @(posedge clk);
    #1;
    check_q1("reset_first_edge", 1'b0);
    check_q4("reset_first_edge_w4", 4'b0000);
    for (int i = 0; i < 3; i++) begin
      drive1(1'b1, 1'bx, 1'bx);
      check_q1($sformatf("reset_hold_%0d", i), 1'b0);
    end

    // Hold / clear / set / toggle / toggle.
    foreach (seq[i]) begin
      drive1(1'b0, seq[i].j, seq[i].k);
      check_q1(seq[i].tag, seq[i].exp);
    end

    // Reset priority over set.
    drive1(1'b0, 1'b1, 1'b0);
    check_q1("prio_pre_set", 1'b1);
    drive1(1'b1, 1'b1, 1'b0);
    check_q1("prio_reset_vs_set", 1'b0);
    drive1(1'b1, 1'b1, 1'b0);
    check_q1("prio_reset_vs_set_held", 1'b0);

    // Reset priority over toggle.
    drive1(1'b0, 1'b1, 1'b0);
    check_q1("prio_pre_set2", 1'b1);
    drive1(1'b1, 1'b1, 1'b1);
    check_q1("prio_reset_vs_toggle", 1'b0);
    drive1(1'b1, 1'b1, 1'b1);
    check_q1("prio_reset_vs_toggle_held", 1'b0);

    // Synchronous reset: asserting it mid-cycle must not disturb q before the edge.
    drive1(1'b0, 1'b1, 1'b0);
    check_q1("sync_pre_set", 1'b1);
    @(negedge clk);
    #20;
    reset = 1'b1;
    j1    = 1'b0;
    k1    = 1'b0;
    #5;
    check_q1("sync_reset_before_edge", 1'b1);
    @(posedge clk);
    #1;
    check_q1("sync_reset_after_edge", 1'b0);

    // First command after reset release lands on the next edge.
    drive1(1'b0, 1'b1, 1'b0);
    check_q1("post_reset_set", 1'b1);

    // Divide-by-2: toggle held for consecutive edges.
    for (int i = 0; i < 4; i++) begin
      drive1(1'b0, 1'b1, 1'b1);
      check_q1($sformatf("div2_%0d", i), logic'(i[0]));
    end

    // Multi-bit: bit3 set, bit2 clear, bit1 toggle 0->1, bit0 hold 0.
    check_q4("w4_start", 4'b0000);
    @(negedge clk);
    #20;
    j1 = 1'b0;
    k1 = 1'b0;
    j4 = 4'b1010;
    k4 = 4'b0110;
    @(posedge clk);
    #1;
    check_q4("w4_mixed", 4'b1010);
    @(negedge clk);
    #20;
    j4 = 4'b1111;
    k4 = 4'b1111;
    @(posedge clk);
    #1;
    check_q4("w4_toggle_all", 4'b0101);

    // Bit0 toggles while bit1 holds, bit2 sets, bit3 clears.
    @(negedge clk);
    #20;
    j4 = 4'b0101;
    k4 = 4'b1001;
    @(posedge clk);
    #1;
    check_q4("w4_indep", 4'b0100);

    @(negedge clk);
    #20;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_q4("w4_reset", 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
